// File: rtl/wide_add_seq_if.sv
// -----------------------------------------------------------------------------
// wide_add_seq_if
//
// Purpose: bundles the signals of the wide_add_seq block. It carries the
// operand handshake, the result handshake, and the narrow adder side-channel
// that the sequencer drives/consumes.
//
// Optional feature macro: WIDE_ADD_OVF_EN. When defined, the out_ovf signal
// exists and appears in both modports.
//
// Signals:
//   in_valid  / in_ready        operand handshake
//   in_a, in_b [W-1:0], in_cin  operands and carry into word 0
//   add_a, add_b [N-1:0]        word slice driven to the external adder
//   add_cin                     carry driven to the external adder
//   add_sum [N-1:0], add_cout   combinational adder result
//   out_valid / out_ready       result handshake
//   out_sum [W-1:0], out_cout   wide result
//   out_ovf                     signed overflow (WIDE_ADD_OVF_EN only)
//
// Modports:
//   slave  - the sequencer (accepts operands, produces results, drives adder)
//   master - the environment around it (requester, consumer and adder)
// -----------------------------------------------------------------------------
interface wide_add_seq_if #(
  parameter int N     = 8,
  parameter int WORDS = 4
);
  localparam int W = N * WORDS;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;

  logic [N-1:0] add_a;
  logic [N-1:0] add_b;
  logic         add_cin;
  logic [N-1:0] add_sum;
  logic         add_cout;

  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
`ifdef WIDE_ADD_OVF_EN
  logic         out_ovf;
`endif

`ifdef WIDE_ADD_OVF_EN
  modport slave (
    input  in_valid, in_a, in_b, in_cin, add_sum, add_cout, out_ready,
    output in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout,
    output out_ovf
  );

  modport master (
    output in_valid, in_a, in_b, in_cin, add_sum, add_cout, out_ready,
    input  in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout,
    input  out_ovf
  );
`else
  modport slave (
    input  in_valid, in_a, in_b, in_cin, add_sum, add_cout, out_ready,
    output in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout
  );

  modport master (
    output in_valid, in_a, in_b, in_cin, add_sum, add_cout, out_ready,
    input  in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout
  );
`endif

endinterface

// File: rtl/wide_add_seq.sv
// -----------------------------------------------------------------------------
// wide_add_seq
//
// Purpose: performs a WORDS x N-bit addition by streaming N-bit word slices,
// least significant first, through an external N-bit carry-chain adder and
// chaining the carry between words. One word is processed per clock.
//
// Optional feature macro: WIDE_ADD_OVF_EN. When defined, a two's-complement
// overflow flag (out_ovf) is produced alongside the wide sum. When undefined
// the flag and its logic are absent; everything else is identical.
//
// Parameters:
//   N     - adder word width in bits
//   WORDS - number of words per operand (must be >= 2); W = N*WORDS
//
// Ports:
//   clk  - sole clock, rising edge
//   rst  - asynchronous, active-high reset
//   bus  - wide_add_seq_if.slave:
//            in_valid/in_ready/in_a/in_b/in_cin    operand handshake
//            add_a/add_b/add_cin -> adder, add_sum/add_cout <- adder
//            out_valid/out_ready/out_sum/out_cout  result handshake
//            out_ovf                               (WIDE_ADD_OVF_EN only)
//
// Behaviour summary:
//   IDLE : in_ready=1. An edge with in_valid=1 latches the operands, loads the
//          carry with in_cin, clears idx and enters RUN.
//   RUN  : one word per edge; the partial sum slice and carry are captured.
//          The edge at idx=WORDS-1 captures the final carry and enters DONE.
//   DONE : out_valid=1 with the result held until an edge with out_ready=1.
//   Latency from accept edge to out_valid is WORDS edges; the minimum
//   initiation interval is WORDS+2 cycles.
// -----------------------------------------------------------------------------
module wide_add_seq #(
  parameter int N     = 8,
  parameter int WORDS = 4
) (
  input  logic             clk,
  input  logic             rst,
  wide_add_seq_if.slave    bus
);

  localparam int W     = N * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             carry;

  // Operand copies taken on the accept edge; later input changes are ignored.
  logic [W-1:0]     a_p0;
  logic [W-1:0]     b_p0;

  logic [W-1:0]     sum_reg;
  logic             cout_reg;
  logic             in_ready_reg;
  logic             out_valid_reg;
`ifdef WIDE_ADD_OVF_EN
  logic             ovf_reg;
`endif

  // Selects word i of a W-bit vector.
  function automatic logic [N-1:0] word_of(input logic [W-1:0]     vec,
                                           input logic [IDX_W-1:0] i);
    return vec[i*N +: N];
  endfunction

`ifdef WIDE_ADD_OVF_EN
  // Two's-complement overflow of the top word: carry out of the MSB XOR the
  // carry into the MSB. The carry into the MSB is recovered from the sum bit
  // and the two operand bits at that position.
  function automatic logic signed_ovf(input logic cout,
                                      input logic sum_msb,
                                      input logic a_msb,
                                      input logic b_msb);
    return cout ^ (sum_msb ^ a_msb ^ b_msb);
  endfunction
`endif

  // ---------------------------------------------------------------------------
  // Operand capture (data only, no reset needed)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.in_valid) begin
      a_p0 <= bus.in_a;
      b_p0 <= bus.in_b;
    end
  end

  // ---------------------------------------------------------------------------
  // Adder drive: decoded only from registered state, idx, carry and the
  // operand copies, so nothing on in_* reaches add_* combinationally.
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.add_a   = '0;
    bus.add_b   = '0;
    bus.add_cin = 1'b0;
    if (state == RUN) begin
      bus.add_a   = word_of(a_p0, idx);
      bus.add_b   = word_of(b_p0, idx);
      bus.add_cin = carry;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM with registered handshake outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= '0;
      carry         <= 1'b0;
      sum_reg       <= '0;
      cout_reg      <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
`ifdef WIDE_ADD_OVF_EN
      ovf_reg       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            idx          <= '0;
            carry        <= bus.in_cin;
            in_ready_reg <= 1'b0;
            state        <= RUN;
          end
        end

        RUN: begin
          sum_reg[idx*N +: N] <= bus.add_sum;
          carry               <= bus.add_cout;
          if (idx == LAST_IDX) begin
            // idx is left at its last value rather than wrapping; it is
            // reloaded on the next accept.
            cout_reg      <= bus.add_cout;
`ifdef WIDE_ADD_OVF_EN
            ovf_reg       <= signed_ovf(bus.add_cout, bus.add_sum[N-1],
                                        bus.add_a[N-1], bus.add_b[N-1]);
`endif
            out_valid_reg <= 1'b1;
            state         <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end

        DONE: begin
          // in_ready is raised on the handshake edge, so a new accept can
          // only occur on the following edge.
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state         <= IDLE;
          end
        end

        default: begin
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
          state         <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_sum   = sum_reg;
  assign bus.out_cout  = cout_reg;
`ifdef WIDE_ADD_OVF_EN
  assign bus.out_ovf   = ovf_reg;
`endif

endmodule
